itype_issue_stage: RTL and testbench
====================================

ITYPE_ISSUE_STAGE -- requirements
Module: itype_issue_stage

Interface
- REQ-001: The block SHALL have these ports (name, direction, width, meaning); clock and reset come first:
  - clk  in  1  single clock; all state updates on rising edge.
  - reset  in  1  synchronous, active-high reset.
  - in_valid  in  1  upstream instruction/operand beat valid.
  - in_ready  out  1  stage can accept a beat this cycle.
  - in_instr  in  32  I-type instruction word: opcode[31:26], rs[25:21], rt[20:16], imm[15:0].
  - in_rs_data  in  32  register value of rs, valid with in_valid.
  - out_valid  out  1  issued ALU beat valid.
  - out_ready  in  1  downstream ALU/execute stage accepts the beat.
  - out_a  out  32  ALU operand a (= rs data).
  - out_b  out  32  ALU operand b (extended immediate).
  - out_alu_op  out  4  ALU control: [3] Ainvert, [2] Binvert/CarryIn, [1:0] Operation (00 AND, 01 OR, 10 ADD, 11 SLT).
  - out_rt  out  5  destination/source register index.
  - out_reg_wr, out_mem_rd, out_mem_wr  out  1 each  writeback / load / store flags.
  - out_illegal  out  1  opcode not supported.
- REQ-002: One clock; reset is synchronous and active-high (ports clk, reset).

Function
- REQ-003: Decode SHALL be as follows (opcode -> alu_op, extension, flags):
  - 001000 addi and 001001 addiu -> 0010, sign-extend, reg_wr.
  - 001010 slti -> 0111, sign-extend, reg_wr.
  - 001100 andi -> 0000, zero-extend, reg_wr.
  - 001101 ori -> 0001, zero-extend, reg_wr.
  - 100011 lw -> 0010, sign-extend, reg_wr and mem_rd.
  - 101011 sw -> 0010, sign-extend, mem_wr.
- REQ-004: Any other opcode SHALL produce out_illegal=1, alu_op=0010, out_b=0 and all write/mem flags 0; the beat still flows.
- REQ-005: A beat is accepted when in_valid and in_ready are both 1; it is transferred when out_valid and out_ready are both 1.
- REQ-006: Latency SHALL be one cycle: a beat accepted at edge N appears on the outputs with out_valid=1 after edge N.
- REQ-007: While out_valid=1 and out_ready=0, all out_* signals SHALL hold stable.
- REQ-008: Beats SHALL be delivered in order, each exactly once; no beat is dropped or duplicated.
- REQ-009: Simultaneous accept and transfer in one cycle SHALL replace the output beat with no bubble, giving full throughput of one beat per cycle.
- REQ-010: Inputs SHALL be ignored when in_valid=0, and when in_ready=0.
- REQ-011: The issue counter issue_cnt (16-bit, internal, observable hierarchically) SHALL increment on each transfer and wrap from 0xFFFF to 0x0000.

Reset
- REQ-012: While reset=1 at a clock edge, the next state SHALL be: out_valid=0, every data/flag output 0, issue_cnt=0, skid buffer empty.
- REQ-013: in_ready SHALL be 0 during the reset cycle and 1 in the first cycle after reset deasserts.
- REQ-014: Reset asserted mid-stall SHALL discard every held beat, with no transfer in that cycle.

Configuration
- REQ-015: Macro ITYPE_ISSUE_SKID_EN defined -> a 2-entry skid buffer is built:
  - in_ready is a register output, equal to "skid empty".
  - A beat accepted while the output is stalled goes into the skid; in_ready drops on the following cycle.
  - The skid entry moves to the output on the next transfer.
- REQ-016: Macro ITYPE_ISSUE_SKID_EN undefined -> single output register; in_ready = !out_valid || out_ready (combinational). Function in REQ-003 to REQ-011 is otherwise identical.

Verification
- REQ-017: addi, instr=0x2022FFFF, rs_data=5 -> next cycle out_a=5, out_b=0xFFFFFFFF, alu_op=0010, rt=2, reg_wr=1.
- REQ-018: andi, imm=0x8000 -> out_b=0x00008000, alu_op=0000; ori -> alu_op 0001; slti -> alu_op 0111 with sign-extended imm.
- REQ-019: opcode 000010 -> out_illegal=1, out_b=0, reg_wr=mem_rd=mem_wr=0; the next legal beat issues normally.
- REQ-020: Stream 8 beats with out_ready low for cycles 3-5 -> outputs held stable during the stall, all 8 delivered in order, issue_cnt=8. With SKID_EN, in_ready drops exactly one cycle after the stall begins.
- REQ-021: Assert reset while a beat is stalled -> out_valid=0 next cycle; that beat is never transferred.
- REQ-022: 65537 back-to-back transfers -> issue_cnt=1, throughput one beat per cycle.

Source files
------------

// File: rtl/itype_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : itype_issue_stage
// Brief    : Decodes I-type instructions into ALU operands and control, then
//            issues them through a valid/ready output register. The optional
//            ITYPE_ISSUE_SKID_EN macro adds a skid entry so that in_ready can
//            be driven from a register.
// Revision : 1.0 - initial release
// ============================================================================
module itype_issue_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_rs_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic [3:0]  out_alu_op,
    output logic [4:0]  out_rt,
    output logic        out_reg_wr,
    output logic        out_mem_rd,
    output logic        out_mem_wr,
    output logic        out_illegal
);

    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_ADDIU = 6'b001001;
    localparam logic [5:0] c_OP_SLTI  = 6'b001010;
    localparam logic [5:0] c_OP_ANDI  = 6'b001100;
    localparam logic [5:0] c_OP_ORI   = 6'b001101;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;

    localparam logic [3:0] c_ALU_AND = 4'b0000;
    localparam logic [3:0] c_ALU_OR  = 4'b0001;
    localparam logic [3:0] c_ALU_ADD = 4'b0010;
    localparam logic [3:0] c_ALU_SLT = 4'b0111;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  alu_op;
        logic [4:0]  rt;
        logic        reg_wr;
        logic        mem_rd;
        logic        mem_wr;
        logic        illegal;
    } beat_t;

    logic [15:0] issue_cnt;
    beat_t       w_dec;
    beat_t       r_out;
    logic        r_out_valid;
    logic        w_accept;
    logic        w_xfer;
    logic [5:0]  w_opcode;
    logic [31:0] w_imm_sext;
    logic [31:0] w_imm_zext;

    assign w_opcode   = in_instr[31:26];
    assign w_imm_sext = {{16{in_instr[15]}}, in_instr[15:0]};
    assign w_imm_zext = {16'h0000, in_instr[15:0]};

    always_comb begin
        w_dec         = '0;
        w_dec.a       = in_rs_data;
        w_dec.rt      = in_instr[20:16];
        w_dec.alu_op  = c_ALU_ADD;
        case (w_opcode)
            c_OP_ADDI, c_OP_ADDIU: begin
                w_dec.b      = w_imm_sext;
                w_dec.reg_wr = 1'b1;
            end
            c_OP_SLTI: begin
                w_dec.alu_op = c_ALU_SLT;
                w_dec.b      = w_imm_sext;
                w_dec.reg_wr = 1'b1;
            end
            c_OP_ANDI: begin
                w_dec.alu_op = c_ALU_AND;
                w_dec.b      = w_imm_zext;
                w_dec.reg_wr = 1'b1;
            end
            c_OP_ORI: begin
                w_dec.alu_op = c_ALU_OR;
                w_dec.b      = w_imm_zext;
                w_dec.reg_wr = 1'b1;
            end
            c_OP_LW: begin
                w_dec.b      = w_imm_sext;
                w_dec.reg_wr = 1'b1;
                w_dec.mem_rd = 1'b1;
            end
            c_OP_SW: begin
                w_dec.b      = w_imm_sext;
                w_dec.mem_wr = 1'b1;
            end
            // Unsupported opcodes still flow downstream, but as a harmless ADD of zero.
            default: begin
                w_dec.illegal = 1'b1;
            end
        endcase
    end

    assign w_accept = in_valid && in_ready;
    assign w_xfer   = r_out_valid && out_ready;

`ifdef ITYPE_ISSUE_SKID_EN
    beat_t r_skid;
    logic  r_skid_valid;

    // Ready is the registered skid-empty flag, masked only while reset is held.
    assign in_ready = !r_skid_valid && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out        <= '0;
            r_out_valid  <= 1'b0;
            r_skid       <= '0;
            r_skid_valid <= 1'b0;
        end else if (!r_out_valid || out_ready) begin
            if (r_skid_valid) begin
                r_out        <= r_skid;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else begin
                r_out_valid <= w_accept;
                if (w_accept) begin
                    r_out <= w_dec;
                end
            end
        end else if (w_accept) begin
            r_skid       <= w_dec;
            r_skid_valid <= 1'b1;
        end
    end
`else
    assign in_ready = !reset && (!r_out_valid || out_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else if (!r_out_valid || out_ready) begin
            r_out_valid <= w_accept;
            if (w_accept) begin
                r_out <= w_dec;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            issue_cnt <= 16'h0000;
        end else if (w_xfer) begin
            issue_cnt <= issue_cnt + 16'h0001;
        end
    end

    assign out_valid   = r_out_valid;
    assign out_a       = r_out.a;
    assign out_b       = r_out.b;
    assign out_alu_op  = r_out.alu_op;
    assign out_rt      = r_out.rt;
    assign out_reg_wr  = r_out.reg_wr;
    assign out_mem_rd  = r_out.mem_rd;
    assign out_mem_wr  = r_out.mem_wr;
    assign out_illegal = r_out.illegal;

endmodule
`default_nettype wire

// File: tb/tb_itype_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_itype_issue_stage
// Brief    : Scoreboard bench for itype_issue_stage with a decode reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_itype_issue_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = 32'h0;
    logic [31:0] in_rs_data = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [3:0]  out_alu_op;
    logic [4:0]  out_rt;
    logic        out_reg_wr;
    logic        out_mem_rd;
    logic        out_mem_wr;
    logic        out_illegal;

    itype_issue_stage dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_rs_data (in_rs_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_a      (out_a),
        .out_b      (out_b),
        .out_alu_op (out_alu_op),
        .out_rt     (out_rt),
        .out_reg_wr (out_reg_wr),
        .out_mem_rd (out_mem_rd),
        .out_mem_wr (out_mem_wr),
        .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    typedef logic [76:0] beat_t;

    beat_t q_sb[$];
    int    tests = 0;
    int    fails = 0;
    int    model_cnt = 0;
    int    xfer_total = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference decode written straight from the opcode table.
    function automatic beat_t model(input logic [31:0] instr, input logic [31:0] rs);
        int          op;
        logic [31:0] b;
        logic [3:0]  alu;
        logic        wr, mr, mw, ill;
        int          imm;
        op  = int'(instr[31:26]);
        imm = int'(instr[15:0]);
        b = 32'h0; alu = 4'd2; wr = 0; mr = 0; mw = 0; ill = 0;
        if (op == 8 || op == 9) begin
            b = (imm >= 32768) ? 32'(imm - 65536) : 32'(imm); wr = 1;
        end else if (op == 10) begin
            b = (imm >= 32768) ? 32'(imm - 65536) : 32'(imm); alu = 4'd7; wr = 1;
        end else if (op == 12) begin
            b = 32'(imm); alu = 4'd0; wr = 1;
        end else if (op == 13) begin
            b = 32'(imm); alu = 4'd1; wr = 1;
        end else if (op == 35) begin
            b = (imm >= 32768) ? 32'(imm - 65536) : 32'(imm); wr = 1; mr = 1;
        end else if (op == 43) begin
            b = (imm >= 32768) ? 32'(imm - 65536) : 32'(imm); mw = 1;
        end else begin
            ill = 1;
        end
        return {rs, b, alu, instr[20:16], wr, mr, mw, ill};
    endfunction

    function automatic beat_t dut_out();
        return {out_a, out_b, out_alu_op, out_rt, out_reg_wr, out_mem_rd, out_mem_wr, out_illegal};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [5:0]  ops [9];
        ops = '{6'd8, 6'd9, 6'd10, 6'd12, 6'd13, 6'd35, 6'd43, 6'd2, 6'd0};
        r = $urandom();
        ops[8] = r[31:26];
        r[31:26] = ops[$urandom_range(0, 8)];
        return r;
    endfunction

    task automatic drive_cycle(input logic v, input logic [31:0] instr, input logic [31:0] rs,
                               input logic ordy, output logic acc);
        @(negedge clk);
        in_valid   = v;
        in_instr   = instr;
        in_rs_data = rs;
        out_ready  = ordy;
        #2;
        acc = in_valid && in_ready;
        if (acc) q_sb.push_back(model(instr, rs));
    endtask

    task automatic do_reset(input logic ordy, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset     = 1'b1;
            in_valid  = 1'b0;
            out_ready = ordy;
        end
        @(negedge clk);
        reset     = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic drain(input int n);
        logic acc;
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 32'h0, 32'h0, 1'b1, acc);
        @(negedge clk);
        #4;
    endtask

    // Monitor: pops the scoreboard on every transfer and checks hold/reset behaviour.
    initial begin : monitor
        logic  started;
        logic  prev_rst;
        logic  stall_hold;
        beat_t held;
        beat_t exp;
        started = 0; prev_rst = 0; stall_hold = 0; held = '0;
        forever begin
            @(negedge clk);
            #3;
            if (started) begin
                if (prev_rst) begin
                    check("reset_out_valid", 128'(out_valid), 128'(0));
                    check("reset_outputs", 128'(dut_out()), 128'(0));
                    if (!reset) check("ready_after_reset", 128'(in_ready), 128'(1));
                end
                if (stall_hold && !prev_rst) begin
                    check("stall_valid_hold", 128'(out_valid), 128'(1));
                    check("stall_data_hold", 128'(dut_out()), 128'(held));
                end
                check("issue_cnt", 128'(dut.issue_cnt), 128'(model_cnt));
            end
            if (reset) begin
                started = 1;
                check("ready_in_reset", 128'(in_ready), 128'(0));
                q_sb.delete();
                model_cnt  = 0;
                stall_hold = 0;
            end else if (started && out_valid && out_ready) begin
                if (q_sb.size() == 0) begin
                    check("unexpected_beat", 128'(dut_out()), 128'(0) - 128'(1));
                end else begin
                    exp = q_sb.pop_front();
                    check("beat", 128'(dut_out()), 128'(exp));
                end
                model_cnt = (model_cnt + 1) % 65536;
                xfer_total++;
                stall_hold = 0;
            end else if (started && out_valid) begin
                stall_hold = 1;
                held       = dut_out();
            end else begin
                stall_hold = 0;
            end
            prev_rst = reset;
        end
    end

    initial begin : driver
        logic acc;
        int   beats;
        int   x0;
        int   nacc;
        logic [31:0] dir_instr [7];
        dir_instr = '{32'h2022FFFF, 32'h30438000, 32'h34641234, 32'h2885FFF0,
                      32'h08A61234, 32'h8CC70004, 32'hACE8FFFC};

        do_reset(1'b1, 2);

        // Directed decode beats, back to back.
        for (int i = 0; i < 7; i++) drive_cycle(1'b1, dir_instr[i], (i == 0) ? 32'd5 : $urandom(), 1'b1, acc);
        drain(3);
        check("directed_drained", 128'(q_sb.size()), 128'(0));

        // Eight-beat stream with the consumer stalled in cycles 3-5.
        do_reset(1'b1, 1);
        beats = 0;
        for (int cyc = 0; cyc < 40 && beats < 8; cyc++) begin
            drive_cycle(1'b1, rand_instr(), $urandom(), !(cyc >= 3 && cyc <= 5), acc);
`ifdef ITYPE_ISSUE_SKID_EN
            if (cyc == 3) check("skid_ready_stall_start", 128'(in_ready), 128'(1));
            if (cyc == 4) check("skid_ready_drop", 128'(in_ready), 128'(0));
`else
            if (cyc == 3) check("ready_stall_start", 128'(in_ready), 128'(0));
`endif
            if (acc) beats++;
        end
        drain(6);
        check("stream_beats", 128'(beats), 128'(8));
        check("stream_issue_cnt", 128'(dut.issue_cnt), 128'(8));
        check("stream_drained", 128'(q_sb.size()), 128'(0));

        // Reset while beats are held; none of them may ever transfer.
        do_reset(1'b1, 1);
        drive_cycle(1'b1, rand_instr(), $urandom(), 1'b0, acc);
        drive_cycle(1'b1, rand_instr(), $urandom(), 1'b0, acc);
        drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, acc);
        x0 = xfer_total;
        do_reset(1'b1, 1);
        drain(3);
        check("midstall_no_xfer", 128'(xfer_total - x0), 128'(0));
        check("midstall_issue_cnt", 128'(dut.issue_cnt), 128'(0));

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            drive_cycle(($urandom_range(0, 9) < 7), rand_instr(), $urandom(),
                        ($urandom_range(0, 9) < 7), acc);
        end
        drain(10);
        check("random_drained", 128'(q_sb.size()), 128'(0));

        // Full-rate burst across the counter wrap.
        do_reset(1'b1, 1);
        x0 = xfer_total;
        nacc = 0;
        for (int i = 0; i < 65537; i++) begin
            drive_cycle(1'b1, rand_instr(), $urandom(), 1'b1, acc);
            if (acc) nacc++;
        end
        drive_cycle(1'b0, 32'h0, 32'h0, 1'b1, acc);
        @(negedge clk);
        #4;
        check("burst_accepts", 128'(nacc), 128'(65537));
        check("burst_xfers", 128'(xfer_total - x0), 128'(65537));
        check("burst_issue_cnt_wrap", 128'(dut.issue_cnt), 128'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
